// File: rtl/sc_timeoutcounter.sv
// Point-drop timeout counter: counts active-low upcount pulses against a level-dependent limit
// and holds an active-low expiry flag until the point state machine clears the counter.
module sc_timeoutcounter #(
    parameter int unsigned            COUNT_WIDTH        = 24,
    parameter logic [COUNT_WIDTH-1:0] LIMIT_L0           = 24'd8_000_000,
    parameter logic [COUNT_WIDTH-1:0] LIMIT_L1           = 24'd4_000_000,
    parameter logic [COUNT_WIDTH-1:0] LIMIT_L2           = 24'd2_000_000,
    parameter logic [COUNT_WIDTH-1:0] LIMIT_L3           = 24'd1_000_000,
    parameter logic [3:0]             EXPIRIES_PER_LEVEL = 4'd8
) (
    input  logic                   SC_STATEMACHINEPOINT_CLOCK_50,
    input  logic                   SC_STATEMACHINEPOINT_RESET_InHigh,
    input  logic                   SC_TIMEOUTCOUNTER_init_InLow,
    input  logic                   SC_TIMEOUTCOUNTER_clear_InLow,
    input  logic                   SC_TIMEOUTCOUNTER_upcount_InLow,
    output logic                   SC_TIMEOUTCOUNTER_T0_OutLow,
    output logic [COUNT_WIDTH-1:0] SC_TIMEOUTCOUNTER_count_Out,
    output logic [1:0]             SC_TIMEOUTCOUNTER_level_Out,
    output logic [3:0]             SC_TIMEOUTCOUNTER_expiries_Out
);

    typedef enum logic {
        COUNTING,
        EXPIRED
    } state_t;

    state_t                 state_q, state_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic [COUNT_WIDTH-1:0] lim_q, lim_d;
    logic [1:0]             level_q, level_d;
    logic [3:0]             expiries_q, expiries_d;
    logic [COUNT_WIDTH-1:0] count_inc;
    logic [3:0]             expiries_inc;

    function automatic logic [COUNT_WIDTH-1:0] limit_for(input logic [1:0] lvl);
        logic [COUNT_WIDTH-1:0] l;
        unique case (lvl)
            2'd0:    l = LIMIT_L0;
            2'd1:    l = LIMIT_L1;
            2'd2:    l = LIMIT_L2;
            default: l = LIMIT_L3;
        endcase
        return l;
    endfunction

    always_ff @(posedge SC_STATEMACHINEPOINT_CLOCK_50 or posedge SC_STATEMACHINEPOINT_RESET_InHigh) begin
        if (SC_STATEMACHINEPOINT_RESET_InHigh) begin
            state_q    <= COUNTING;
            count_q    <= '0;
            lim_q      <= LIMIT_L0;
            level_q    <= '0;
            expiries_q <= '0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            lim_q      <= lim_d;
            level_q    <= level_d;
            expiries_q <= expiries_d;
        end
    end

    assign count_inc    = count_q + COUNT_WIDTH'(1);
    assign expiries_inc = expiries_q + 4'd1;

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        lim_d      = lim_q;
        level_d    = level_q;
        expiries_d = expiries_q;

        if (!SC_TIMEOUTCOUNTER_init_InLow) begin
            state_d    = COUNTING;
            count_d    = '0;
            lim_d      = limit_for(2'd0);
            level_d    = '0;
            expiries_d = '0;
        end else if (!SC_TIMEOUTCOUNTER_clear_InLow) begin
            // level_q already reflects the expiry that preceded this clear
            state_d = COUNTING;
            count_d = '0;
            lim_d   = limit_for(level_q);
        end else begin
            unique case (state_q)
                COUNTING: begin
                    if (!SC_TIMEOUTCOUNTER_upcount_InLow) begin
                        count_d = count_inc;
                        if (count_inc == lim_q) begin
                            state_d = EXPIRED;
                            if (expiries_inc == EXPIRIES_PER_LEVEL) begin
                                expiries_d = '0;
                                if (level_q != 2'd3) begin
                                    level_d = level_q + 2'd1;
                                end
                            end else begin
                                expiries_d = expiries_inc;
                            end
                        end
                    end
                end
                EXPIRED: begin
                    state_d = EXPIRED;
                end
                default: begin
                    state_d = COUNTING;
                end
            endcase
        end
    end

    assign SC_TIMEOUTCOUNTER_T0_OutLow    = (state_q != EXPIRED);
    assign SC_TIMEOUTCOUNTER_count_Out    = count_q;
    assign SC_TIMEOUTCOUNTER_level_Out    = level_q;
    assign SC_TIMEOUTCOUNTER_expiries_Out = expiries_q;

endmodule

// File: tb/tb_sc_timeoutcounter.sv
// Self-checking bench for sc_timeoutcounter: directed vector table, multi-cycle corner
// sequences, and randomized traffic against a behavioural model.
module tb_sc_timeoutcounter;

    localparam int EPL = 2;

    logic        clk;
    logic        rst;
    logic        init_n;
    logic        clr_n;
    logic        up_n;
    logic        t0;
    logic [23:0] count;
    logic [1:0]  level;
    logic [3:0]  expiries;

    int checks;
    int failures;

    int m_cnt;
    int m_lim;
    int m_lvl;
    int m_ex;
    bit m_expired;
    int lims [4];

    typedef struct {
        bit i;
        bit c;
        bit u;
        bit t0;
        int cnt;
        int lvl;
        int ex;
    } vec_t;

    vec_t tbl[$];

    sc_timeoutcounter #(
        .COUNT_WIDTH       (24),
        .LIMIT_L0          (24'd4),
        .LIMIT_L1          (24'd3),
        .LIMIT_L2          (24'd2),
        .LIMIT_L3          (24'd1),
        .EXPIRIES_PER_LEVEL(4'd2)
    ) dut (
        .SC_STATEMACHINEPOINT_CLOCK_50    (clk),
        .SC_STATEMACHINEPOINT_RESET_InHigh(rst),
        .SC_TIMEOUTCOUNTER_init_InLow     (init_n),
        .SC_TIMEOUTCOUNTER_clear_InLow    (clr_n),
        .SC_TIMEOUTCOUNTER_upcount_InLow  (up_n),
        .SC_TIMEOUTCOUNTER_T0_OutLow      (t0),
        .SC_TIMEOUTCOUNTER_count_Out      (count),
        .SC_TIMEOUTCOUNTER_level_Out      (level),
        .SC_TIMEOUTCOUNTER_expiries_Out   (expiries)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            failures++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    task automatic check_const(input string tag, input bit w_t0, input int w_cnt, input int w_lvl, input int w_ex);
        check({tag, ".t0"}, int'(t0), int'(w_t0));
        check({tag, ".count"}, int'(count), w_cnt);
        check({tag, ".level"}, int'(level), w_lvl);
        check({tag, ".expiries"}, int'(expiries), w_ex);
    endtask

    task automatic check_model(input string tag);
        check_const(tag, !m_expired, m_cnt, m_lvl, m_ex);
    endtask

    function automatic void model_reset();
        m_cnt     = 0;
        m_lvl     = 0;
        m_ex      = 0;
        m_expired = 0;
        m_lim     = lims[0];
    endfunction

    // Behaviour as stated: init beats clear beats upcount; pulses ignored while expired.
    function automatic void model_step(input bit i, input bit c, input bit u);
        if (!i) begin
            model_reset();
        end else if (!c) begin
            m_cnt     = 0;
            m_expired = 0;
            m_lim     = lims[m_lvl];
        end else if (!u && !m_expired) begin
            m_cnt++;
            if (m_cnt == m_lim) begin
                m_expired = 1;
                m_ex++;
                if (m_ex == EPL) begin
                    m_ex = 0;
                    if (m_lvl < 3) m_lvl++;
                end
            end
        end
    endfunction

    task automatic step(input bit i, input bit c, input bit u);
        init_n = i;
        clr_n  = c;
        up_n   = u;
        @(posedge clk);
        #1;
        model_step(i, c, u);
        init_n = 1'b1;
        clr_n  = 1'b1;
        up_n   = 1'b1;
    endtask

    task automatic expire_once(input string tag);
        step(1, 0, 1);
        check_model({tag, ".clr"});
        for (int k = 0; k < 8 && !m_expired; k++) begin
            step(1, 1, 0);
            check_model({tag, ".up"});
        end
        check({tag, ".expired_in_budget"}, int'(m_expired), 1);
    endtask

    function automatic void add(input bit i, input bit c, input bit u, input bit w_t0,
                                input int w_cnt, input int w_lvl, input int w_ex);
        vec_t v;
        v.i = i; v.c = c; v.u = u; v.t0 = w_t0; v.cnt = w_cnt; v.lvl = w_lvl; v.ex = w_ex;
        tbl.push_back(v);
    endfunction

    initial begin
        checks   = 0;
        failures = 0;
        lims     = '{4, 3, 2, 1};
        rst      = 1'b1;
        init_n   = 1'b1;
        clr_n    = 1'b1;
        up_n     = 1'b1;
        model_reset();

        add(1,1,0, 1,1,0,0); add(1,1,0, 1,2,0,0); add(1,1,0, 1,3,0,0);
        add(1,1,0, 0,4,0,1);
        for (int k = 0; k < 5; k++) add(1,1,0, 0,4,0,1);
        add(1,0,1, 1,0,0,1);
        add(1,1,0, 1,1,0,1); add(1,1,0, 1,2,0,1); add(1,1,0, 1,3,0,1);
        add(1,1,0, 0,4,1,0);
        add(1,0,1, 1,0,1,0);
        add(1,1,0, 1,1,1,0); add(1,1,0, 1,2,1,0); add(1,1,0, 0,3,1,1);
        add(1,0,1, 1,0,1,1);
        add(1,1,0, 1,1,1,1); add(1,1,0, 1,2,1,1);
        add(1,0,0, 1,0,1,1);
        add(1,1,0, 1,1,1,1); add(1,1,0, 1,2,1,1); add(1,1,0, 0,3,2,0);
        add(1,0,1, 1,0,2,0); add(1,1,0, 1,1,2,0); add(1,1,0, 0,2,2,1);
        add(1,0,1, 1,0,2,1); add(1,1,0, 1,1,2,1); add(1,1,0, 0,2,3,0);
        add(1,0,1, 1,0,3,0); add(1,1,0, 0,1,3,1);
        add(1,0,1, 1,0,3,1); add(1,1,0, 0,1,3,0);
        add(1,0,1, 1,0,3,0); add(1,1,0, 0,1,3,1);
        add(1,1,1, 0,1,3,1); add(1,1,0, 0,1,3,1);

        #12;
        check_const("reset", 1'b1, 0, 0, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        foreach (tbl[n]) begin
            step(tbl[n].i, tbl[n].c, tbl[n].u);
            check_const($sformatf("vec%0d", n), tbl[n].t0, tbl[n].cnt, tbl[n].lvl, tbl[n].ex);
        end

        // Init while expired at level 2, then a full level-0 limit is needed again.
        step(0, 1, 1);
        check_model("init_a");
        for (int k = 0; k < 5; k++) expire_once($sformatf("climb%0d", k));
        check_const("lvl2_expired", 1'b0, 2, 2, 1);
        step(0, 1, 1);
        check_const("init_release", 1'b1, 0, 0, 0);
        for (int k = 0; k < 3; k++) step(1, 1, 0);
        check_const("init_3up", 1'b1, 3, 0, 0);
        step(1, 1, 0);
        check_const("init_4up", 1'b0, 4, 0, 1);

        // Async reset between edges at level 1, count 2.
        expire_once("to_lvl1");
        check_model("to_lvl1_state");
        step(1, 0, 1);
        step(1, 1, 0);
        step(1, 1, 0);
        check_const("pre_async", 1'b1, 2, 1, 0);
        #3;
        rst = 1'b1;
        #1;
        check_const("async_rst", 1'b1, 0, 0, 0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_model("post_async");

        for (int n = 0; n < 1500; n++) begin
            bit ri, rc, ru;
            ri = ($urandom_range(0, 63) != 0);
            rc = ($urandom_range(0, 15) != 0);
            ru = ($urandom_range(0, 2) == 0);
            step(ri, rc, ru);
            check_model($sformatf("rnd%0d", n));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
